// File: rtl/running_high_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : running_high_event_logger
// Description : Watches the running-high stream and logs every change of the
//               maximum as a {direction, timestamp, value} event. Events are
//               buffered in a first-word fall-through FIFO and drained through
//               a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   high_in     in   running-high sample, one per cycle
//   evt_valid   out  FIFO head holds an event
//   evt_ready   in   consumer accepts head event
//   evt_value   out  new maximum of head event
//   evt_dir     out  1 = rise, 0 = fall
//   evt_ts      out  cycle timestamp of head event
//   fifo_count  out  number of queued events
//   overflow    out  sticky: an event was dropped (FIFO full)
//   clear_ovf   in   synchronous clear of overflow
//   drop_count  out  saturating dropped-event counter
//                    (only with RUNNING_HIGH_EVT_DROPCNT_EN defined)
// Optional macro: RUNNING_HIGH_EVT_DROPCNT_EN
// ============================================================================
module running_high_event_logger #(
   parameter int WIDTH      = 4,
   parameter int TS_WIDTH   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int WARMUP     = 4
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [WIDTH-1:0]                high_in,
   output logic                            evt_valid,
   input  logic                            evt_ready,
   output logic [WIDTH-1:0]                evt_value,
   output logic                            evt_dir,
   output logic [TS_WIDTH-1:0]             evt_ts,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            overflow,
`ifdef RUNNING_HIGH_EVT_DROPCNT_EN
   output logic [7:0]                      drop_count,
`endif
   input  logic                            clear_ovf
);

   localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W  = c_PTR_W + 1;
   localparam int c_WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam int c_ENT_W  = 1 + TS_WIDTH + WIDTH;

   logic [TS_WIDTH-1:0] r_ts_cnt;
   logic [c_WARM_W-1:0] r_warm_cnt;
   logic [WIDTH-1:0]    r_prev_high;
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic                r_overflow;
   logic [c_ENT_W-1:0]  r_mem [FIFO_DEPTH];

   logic                w_det_en;
   logic                w_change;
   logic                w_full;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic [c_ENT_W-1:0]  w_head;

   assign w_det_en = (r_warm_cnt == c_WARM_W'(WARMUP));
   assign w_change = w_det_en && (high_in != r_prev_high);
   assign w_full   = (r_count == c_CNT_W'(FIFO_DEPTH));
   assign w_pop    = (r_count != '0) && evt_ready;
   // A full FIFO can still accept a new entry when the head leaves this cycle.
   assign w_push   = w_change && (!w_full || w_pop);
   assign w_drop   = w_change && w_full && !w_pop;

   // Entry layout: {dir, ts, value}
   assign w_head     = r_mem[r_rd_ptr];
   assign evt_dir    = w_head[c_ENT_W-1];
   assign evt_ts     = w_head[TS_WIDTH+WIDTH-1:WIDTH];
   assign evt_value  = w_head[WIDTH-1:0];
   assign evt_valid  = (r_count != '0);
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ts_cnt    <= '0;
         r_warm_cnt  <= '0;
         r_prev_high <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_ts_cnt    <= r_ts_cnt + TS_WIDTH'(1);
         r_prev_high <= high_in;
         if (!w_det_en) begin
            r_warm_cnt <= r_warm_cnt + c_WARM_W'(1);
         end

         if (w_push) begin
            r_mem[r_wr_ptr] <= {(high_in > r_prev_high), r_ts_cnt, high_in};
            r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - c_CNT_W'(1);
         end

         // A new drop takes priority over a simultaneous clear.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clear_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

`ifdef RUNNING_HIGH_EVT_DROPCNT_EN
   logic [7:0] r_drop_count;

   assign drop_count = r_drop_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drop_count <= '0;
      end else if (clear_ovf) begin
         r_drop_count <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop && (r_drop_count != 8'hFF)) begin
         r_drop_count <= r_drop_count + 8'd1;
      end
   end
`endif

endmodule
`default_nettype wire
